// File: rtl/vec_cfu_pkg.sv
// vec_cfu_pkg
// Shared definitions for the vector MAC CFU: funct3 opcode values, the
// command FSM state type, product width and small elaboration-time helpers.
// Optional feature macro: VEC_CFU_INPUT_OFFSET_EN (widens lane products so
// that the A operand can carry a signed input offset).
package vec_cfu_pkg;

   localparam logic [2:0] OP_WRITE      = 3'd0;
   localparam logic [2:0] OP_READ       = 3'd1;
   localparam logic [2:0] OP_DOT        = 3'd2;
   localparam logic [2:0] OP_BSUM       = 3'd3;
   localparam logic [2:0] OP_ACC_READ   = 3'd4;
   localparam logic [2:0] OP_SET_OFFSET = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

   // A byte plus a 9-bit offset needs 10 bits to be exact, so its product
   // with a signed byte needs 18 bits; raw int8 x int8 fits in 16.
`ifdef VEC_CFU_INPUT_OFFSET_EN
   localparam int PROD_W = 18;
`else
   localparam int PROD_W = 16;
`endif

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // Width of a counter/index that must hold 0..count-1 (at least 1 bit).
   function automatic int ctrW(input int count);
      return (count <= 1) ? 1 : clog2(count);
   endfunction

endpackage

// File: rtl/vec_lane_mac.sv
// vec_lane_mac
// Combinational signed int8 multiply of LANES byte pairs, reduced to one
// signed partial sum through a binary adder tree.
// Ports:
//   aBytes_i  LANES packed A bytes, byte i at [8i+7:8i]
//   bBytes_i  LANES packed B bytes, byte i at [8i+7:8i]
//   offset_i  signed 9-bit offset added to every A byte
//             (present only with VEC_CFU_INPUT_OFFSET_EN)
//   psum_o    signed sum of the LANES products
module vec_lane_mac
   import vec_cfu_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int PSUM_W = PROD_W + clog2(LANES)
)
(
   input  logic [8*LANES-1:0]        aBytes_i,
   input  logic [8*LANES-1:0]        bBytes_i,
`ifdef VEC_CFU_INPUT_OFFSET_EN
   input  logic signed [8:0]         offset_i,
`endif
   output logic signed [PSUM_W-1:0]  psum_o
);

   localparam int LEVELS = clog2(LANES);
   localparam int P      = 1 << LEVELS;

   // Leaves hold the per-lane products (padded with zeros up to a power of
   // two); each tree level then folds pairs in place, lower half first, so
   // a slot is only overwritten after both of its inputs have been read.
   always_comb begin
      logic signed [PSUM_W-1:0] node [P];
      logic signed [PSUM_W-1:0] aWide;
      logic signed [PSUM_W-1:0] bWide;
      for (int i = 0; i < P; i++) begin
         node[i] = '0;
      end
      for (int i = 0; i < LANES; i++) begin
         aWide = PSUM_W'(signed'(aBytes_i[8*i +: 8]));
`ifdef VEC_CFU_INPUT_OFFSET_EN
         aWide = aWide + PSUM_W'(offset_i);
`endif
         bWide = PSUM_W'(signed'(bBytes_i[8*i +: 8]));
         node[i] = aWide * bWide;
      end
      for (int lv = 0; lv < LEVELS; lv++) begin
         for (int i = 0; i < (P >> (lv + 1)); i++) begin
            node[i] = node[2*i] + node[2*i+1];
         end
      end
      psum_o = node[0];
   end

endmodule

// File: rtl/vec_mac_cfu.sv
// vec_mac_cfu
// Multi-cycle CFU with a private vector register file. Executes word
// write/read, int8 dot-product/MAC over LANES bytes per cycle, byte
// reduction and accumulator read commands behind a valid/ready handshake,
// one command in flight (IDLE -> [RUN] -> RESP -> IDLE).
// Optional feature macro: VEC_CFU_INPUT_OFFSET_EN (SET_OFFSET loads a
// signed 9-bit offset that is added to every A byte during DOT).
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only in IDLE)
//   cmd_payload_function_id  [2:0] funct3 opcode, [9:3] funct7 modifier
//   cmd_payload_inputs_0/1   32-bit operands
//   rsp_valid / rsp_ready    response handshake (valid only in RESP)
//   rsp_payload_outputs_0    32-bit result, held stable while in RESP
module vec_mac_cfu
   import vec_cfu_pkg::*;
#(
   parameter int VLEN      = 256,
   parameter int NUM_VREGS = 8,
   parameter int LANES     = 4,
   parameter int ACC_W     = 32
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_payload_function_id,
   input  logic [31:0] cmd_payload_inputs_0,
   input  logic [31:0] cmd_payload_inputs_1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_payload_outputs_0
);

   localparam int WORDS  = VLEN / 32;
   localparam int BEATS  = VLEN / (8 * LANES);
   localparam int NBYTES = VLEN / 8;
   localparam int RB     = clog2(NUM_VREGS);
   localparam int WI     = ctrW(WORDS);
   localparam int BW     = ctrW(BEATS);
   localparam int PSUM_W = PROD_W + clog2(LANES);

   state_t                   state_q, state_d;
   logic [VLEN-1:0]          regfile_q [NUM_VREGS];
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [BW-1:0]            beat_q, beat_d;
   logic [RB-1:0]            aIdx_q, aIdx_d;
   logic [RB-1:0]            bIdx_q, bIdx_d;
   logic [31:0]              rspData_q, rspData_d;
`ifdef VEC_CFU_INPUT_OFFSET_EN
   logic signed [8:0]        offset_q, offset_d;
`endif

   logic [2:0]               funct3;
   logic [6:0]               funct7;
   logic [RB-1:0]            cmdReg;
   logic [RB-1:0]            cmdRegA;
   logic [RB-1:0]            cmdRegB;
   logic [WI-1:0]            cmdWord;
   logic                     accept;
   logic                     regWe;
   logic [VLEN-1:0]          readVec;
   logic [VLEN-1:0]          bsumVec;
   logic [VLEN-1:0]          dotAVec;
   logic [VLEN-1:0]          dotBVec;
   logic [31:0]              readWord;
   logic signed [31:0]       byteSum;
   logic [8*LANES-1:0]       laneA;
   logic [8*LANES-1:0]       laneB;
   logic signed [PSUM_W-1:0] laneSum;
   logic signed [ACC_W-1:0]  accNext;
   logic                     unusedOk;

   assign funct3  = cmd_payload_function_id[2:0];
   assign funct7  = cmd_payload_function_id[9:3];
   assign cmdReg  = funct7[RB-1:0];
   assign cmdRegA = cmd_payload_inputs_0[RB-1:0];
   assign cmdRegB = cmd_payload_inputs_1[RB-1:0];
   assign cmdWord = WI'(cmd_payload_inputs_1 % 32'(WORDS));

   assign cmd_ready             = (state_q == IDLE);
   assign rsp_valid             = (state_q == RESP);
   assign rsp_payload_outputs_0 = rspData_q;
   assign accept                = cmd_valid && cmd_ready;
   assign regWe                 = accept && (funct3 == OP_WRITE);

   assign unusedOk = ^{cmd_payload_function_id};

   assign readVec  = regfile_q[cmdReg];
   assign readWord = readVec[cmdWord*32 +: 32];
   assign bsumVec  = regfile_q[cmdRegA];

   // DOT walks the latched register pair one LANES-byte slice per beat.
   assign dotAVec = regfile_q[aIdx_q];
   assign dotBVec = regfile_q[bIdx_q];
   assign laneA   = dotAVec[beat_q*(8*LANES) +: 8*LANES];
   assign laneB   = dotBVec[beat_q*(8*LANES) +: 8*LANES];

   vec_lane_mac #(
      .LANES  (LANES),
      .PSUM_W (PSUM_W)
   ) u_lane_mac (
      .aBytes_i (laneA),
      .bBytes_i (laneB),
`ifdef VEC_CFU_INPUT_OFFSET_EN
      .offset_i (offset_q),
`endif
      .psum_o   (laneSum)
   );

   assign accNext = acc_q + ACC_W'(laneSum);

   // Whole-register byte reduction for BSUM; a 32-bit signed sum cannot
   // overflow for any register up to 2^24 bytes.
   always_comb begin
      byteSum = '0;
      for (int i = 0; i < NBYTES; i++) begin
         byteSum = byteSum + 32'(signed'(bsumVec[8*i +: 8]));
      end
   end

   // Next-state logic for the command FSM, the accumulator, the response
   // register and (optionally) the input offset.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      beat_d    = beat_q;
      aIdx_d    = aIdx_q;
      bIdx_d    = bIdx_q;
      rspData_d = rspData_q;
`ifdef VEC_CFU_INPUT_OFFSET_EN
      offset_d  = offset_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = RESP;
               rspData_d = '0;
               case (funct3)
                  OP_READ: begin
                     rspData_d = readWord;
                  end
                  OP_DOT: begin
                     state_d = RUN;
                     beat_d  = '0;
                     aIdx_d  = cmdRegA;
                     bIdx_d  = cmdRegB;
                     if (!funct7[0]) begin
                        acc_d = '0;
                     end
                  end
                  OP_BSUM: begin
                     rspData_d = byteSum;
                  end
                  OP_ACC_READ: begin
                     rspData_d = 32'(acc_q);
                     if (funct7[0]) begin
                        acc_d = '0;
                     end
                  end
                  OP_SET_OFFSET: begin
`ifdef VEC_CFU_INPUT_OFFSET_EN
                     offset_d = signed'(cmd_payload_inputs_0[8:0]);
`endif
                  end
                  default: begin
                  end
               endcase
            end
         end
         RUN: begin
            acc_d  = accNext;
            beat_d = beat_q + 1'b1;
            if (beat_q == BW'(BEATS - 1)) begin
               state_d   = RESP;
               rspData_d = 32'(accNext);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers plus the register file; WRITE lands on the accept edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         beat_q    <= '0;
         aIdx_q    <= '0;
         bIdx_q    <= '0;
         rspData_q <= '0;
`ifdef VEC_CFU_INPUT_OFFSET_EN
         offset_q  <= '0;
`endif
         for (int r = 0; r < NUM_VREGS; r++) begin
            regfile_q[r] <= '0;
         end
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         beat_q    <= beat_d;
         aIdx_q    <= aIdx_d;
         bIdx_q    <= bIdx_d;
         rspData_q <= rspData_d;
`ifdef VEC_CFU_INPUT_OFFSET_EN
         offset_q  <= offset_d;
`endif
         if (regWe) begin
            regfile_q[cmdReg][cmdWord*32 +: 32] <= cmd_payload_inputs_0;
         end
      end
   end

endmodule

// File: tb/tb_vec_mac_cfu.sv
// tb_vec_mac_cfu
// Self-checking bench for vec_mac_cfu: directed scenarios plus randomized
// commands, all checked against a word/byte-level reference model.
module tb_vec_mac_cfu;

   localparam int VLEN      = 256;
   localparam int NUM_VREGS = 8;
   localparam int LANES     = 4;
   localparam int ACC_W     = 32;
   localparam int WORDS     = VLEN / 32;
   localparam int NBYTES    = VLEN / 8;
   localparam int BEATS     = VLEN / (8 * LANES);

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  fid;
   logic [31:0] in0;
   logic [31:0] in1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rspData;

   int assertCount = 0;
   int failCount   = 0;

   // Reference model state.
   logic [31:0] mRegs [NUM_VREGS][WORDS];
   int          mAcc;
   int          mOffset;

   vec_mac_cfu #(
      .VLEN      (VLEN),
      .NUM_VREGS (NUM_VREGS),
      .LANES     (LANES),
      .ACC_W     (ACC_W)
   ) dut (
      .clk                     (clk),
      .reset                   (reset),
      .cmd_valid               (cmd_valid),
      .cmd_ready               (cmd_ready),
      .cmd_payload_function_id (fid),
      .cmd_payload_inputs_0    (in0),
      .cmd_payload_inputs_1    (in1),
      .rsp_valid               (rsp_valid),
      .rsp_ready               (rsp_ready),
      .rsp_payload_outputs_0   (rspData)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int mByte(input int r, input int i);
      logic [31:0] w;
      logic [7:0]  b;
      w = mRegs[r][i / 4];
      b = w[8*(i % 4) +: 8];
      return int'($signed(b));
   endfunction

   task automatic modelClear();
      for (int r = 0; r < NUM_VREGS; r++) begin
         for (int w = 0; w < WORDS; w++) begin
            mRegs[r][w] = 32'h0;
         end
      end
      mAcc    = 0;
      mOffset = 0;
   endtask

   // Reference behaviour of one command: expected response and latency.
   task automatic modelExec(input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] a0, input logic [31:0] a1,
                            output logic [31:0] expData, output int expLat);
      int          s;
      int          ra;
      int          rb;
      logic [8:0]  t9;
      expData = 32'h0;
      expLat  = 1;
      ra = int'(a0 % NUM_VREGS);
      rb = int'(a1 % NUM_VREGS);
      case (f3)
         3'd0: mRegs[int'(f7) % NUM_VREGS][int'(a1 % WORDS)] = a0;
         3'd1: expData = mRegs[int'(f7) % NUM_VREGS][int'(a1 % WORDS)];
         3'd2: begin
            if (!f7[0]) mAcc = 0;
            s = 0;
            for (int i = 0; i < NBYTES; i++) begin
               s += (mByte(ra, i) + mOffset) * mByte(rb, i);
            end
            mAcc += s;
            expData = mAcc;
            expLat  = 1 + BEATS;
         end
         3'd3: begin
            s = 0;
            for (int i = 0; i < NBYTES; i++) s += mByte(ra, i);
            expData = s;
         end
         3'd4: begin
            expData = mAcc;
            if (f7[0]) mAcc = 0;
         end
         3'd5: begin
`ifdef VEC_CFU_INPUT_OFFSET_EN
            t9 = a0[8:0];
            mOffset = int'($signed(t9));
`else
            t9 = 9'h0;
`endif
         end
         default: expData = 32'h0;
      endcase
   endtask

   task automatic applyStimulus(input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a0, input logic [31:0] a1);
      int waitCycles;
      waitCycles = 0;
      @(negedge clk);
      while (!cmd_ready && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      if (cmd_ready) begin
         fid = {f7, f3};
         in0 = a0;
         in1 = a1;
         cmd_valid = 1'b1;
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
      end
   endtask

   // Waits (bounded) for the response, then accepts it; lat is -1 on timeout.
   task automatic collectRsp(output int lat, output logic [31:0] data);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 100);
      if (!rsp_valid) lat = -1;
      data = rspData;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic doCmd(input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a0, input logic [31:0] a1,
                        output logic [31:0] data, output int lat,
                        output logic [31:0] expData, output int expLat);
      modelExec(f3, f7, a0, a1, expData, expLat);
      applyStimulus(f3, f7, a0, a1);
      collectRsp(lat, data);
   endtask

   task automatic fillReg(input int r, input logic [31:0] value);
      logic [31:0] d, e;
      int l, el;
      for (int w = 0; w < WORDS; w++) begin
         doCmd(3'd0, 7'(r), value, 32'(w), d, l, e, el);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      fid = '0;
      in0 = '0;
      in1 = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      modelClear();
      @(negedge clk);
      assertCount++;
      if (cmd_ready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
      end
      assertCount++;
      if (rsp_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
      end
      assertCount++;
      if (rspData !== 32'h0) begin
         failCount++;
         $display("[TB] FAIL reset_rsp_data: got %h expected 0", rspData);
      end
   endtask

   task automatic test_write_read();
      logic [31:0] d, e;
      int l, el;
      doCmd(3'd0, 7'd1, 32'hDEADBEEF, 32'd3, d, l, e, el);
      assertCount++;
      if (d !== e || l != el) begin
         failCount++;
         $display("[TB] FAIL write_rsp: got %h lat %0d expected %h lat %0d", d, l, e, el);
      end
      doCmd(3'd1, 7'd1, 32'h0, 32'd3, d, l, e, el);
      assertCount++;
      if (d !== e || l != el) begin
         failCount++;
         $display("[TB] FAIL read_word3: got %h lat %0d expected %h lat %0d", d, l, e, el);
      end
      doCmd(3'd1, 7'd1, 32'h0, 32'd11, d, l, e, el);
      assertCount++;
      if (d !== e || l != el) begin
         failCount++;
         $display("[TB] FAIL read_word11_wrap: got %h lat %0d expected %h lat %0d", d, l, e, el);
      end
   endtask

   task automatic test_dot();
      logic [31:0] d, e;
      int l, el;
      fillReg(1, 32'h02020202);
      fillReg(2, 32'hFFFFFFFF);
      doCmd(3'd2, 7'd0, 32'd1, 32'd2, d, l, e, el);
      assertCount++;
      if (d !== e || l != el) begin
         failCount++;
         $display("[TB] FAIL dot_clear: got %h lat %0d expected %h lat %0d", d, l, e, el);
      end
      doCmd(3'd2, 7'd1, 32'd1, 32'd2, d, l, e, el);
      assertCount++;
      if (d !== e || l != el) begin
         failCount++;
         $display("[TB] FAIL dot_accumulate: got %h lat %0d expected %h lat %0d", d, l, e, el);
      end
      doCmd(3'd4, 7'd1, 32'h0, 32'h0, d, l, e, el);
      assertCount++;
      if (d !== e || l != el) begin
         failCount++;
         $display("[TB] FAIL acc_read_clear: got %h lat %0d expected %h lat %0d", d, l, e, el);
      end
      doCmd(3'd4, 7'd0, 32'h0, 32'h0, d, l, e, el);
      assertCount++;
      if (d !== e || l != el) begin
         failCount++;
         $display("[TB] FAIL acc_read_after_clear: got %h lat %0d expected %h lat %0d", d, l, e, el);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      int el;
      int lat;
      modelExec(3'd2, 7'd0, 32'd1, 32'd2, e, el);
      applyStimulus(3'd2, 7'd0, 32'd1, 32'd2);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 100);
      assertCount++;
      if (lat != el || rspData !== e) begin
         failCount++;
         $display("[TB] FAIL bp_first: got %h lat %0d expected %h lat %0d", rspData, lat, e, el);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         assertCount++;
         if (rsp_valid !== 1'b1 || rspData !== e || cmd_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL bp_hold%0d: got valid %b data %h ready %b expected 1 %h 0",
                     c, rsp_valid, rspData, cmd_ready, e);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      assertCount++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL bp_release: got ready %b valid %b expected 1 0", cmd_ready, rsp_valid);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] d, e;
      int l, el;
      applyStimulus(3'd2, 7'd1, 32'd1, 32'd2);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      modelClear();
      @(negedge clk);
      assertCount++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rspData !== 32'h0) begin
         failCount++;
         $display("[TB] FAIL midrun_reset: got ready %b valid %b data %h expected 1 0 0",
                  cmd_ready, rsp_valid, rspData);
      end
      doCmd(3'd1, 7'd1, 32'h0, 32'd2, d, l, e, el);
      assertCount++;
      if (d !== e || l != el) begin
         failCount++;
         $display("[TB] FAIL midrun_read_r1: got %h lat %0d expected %h lat %0d", d, l, e, el);
      end
      doCmd(3'd1, 7'd2, 32'h0, 32'd7, d, l, e, el);
      assertCount++;
      if (d !== e || l != el) begin
         failCount++;
         $display("[TB] FAIL midrun_read_r2: got %h lat %0d expected %h lat %0d", d, l, e, el);
      end
      doCmd(3'd4, 7'd0, 32'h0, 32'h0, d, l, e, el);
      assertCount++;
      if (d !== e || l != el) begin
         failCount++;
         $display("[TB] FAIL midrun_acc: got %h lat %0d expected %h lat %0d", d, l, e, el);
      end
   endtask

   task automatic test_bsum();
      logic [31:0] d, e, w;
      int l, el;
      for (int j = 0; j < WORDS; j++) begin
         w = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
         doCmd(3'd0, 7'd3, w, 32'(j), d, l, e, el);
      end
      doCmd(3'd3, 7'd0, 32'd3, 32'h0, d, l, e, el);
      assertCount++;
      if (d !== e || l != el) begin
         failCount++;
         $display("[TB] FAIL bsum_ramp: got %h lat %0d expected %h lat %0d", d, l, e, el);
      end
      fillReg(3, 32'h80808080);
      doCmd(3'd3, 7'd0, 32'd3, 32'h0, d, l, e, el);
      assertCount++;
      if (d !== e || l != el) begin
         failCount++;
         $display("[TB] FAIL bsum_min: got %h lat %0d expected %h lat %0d", d, l, e, el);
      end
   endtask

   task automatic test_offset();
      logic [31:0] d, e;
      int l, el;
      fillReg(4, 32'h80808080);
      fillReg(5, 32'h01010101);
      doCmd(3'd5, 7'd0, 32'd128, 32'h0, d, l, e, el);
      assertCount++;
      if (d !== e || l != el) begin
         failCount++;
         $display("[TB] FAIL set_offset: got %h lat %0d expected %h lat %0d", d, l, e, el);
      end
      doCmd(3'd2, 7'd0, 32'd4, 32'd5, d, l, e, el);
      assertCount++;
      if (d !== e || l != el) begin
         failCount++;
         $display("[TB] FAIL dot_offset: got %h lat %0d expected %h lat %0d", d, l, e, el);
      end
   endtask

   task automatic test_random();
      logic [31:0] d, e, a0, a1;
      logic [2:0]  f3;
      logic [6:0]  f7;
      int l, el;
      for (int n = 0; n < 60; n++) begin
         f3 = 3'($urandom_range(0, 7));
         f7 = 7'($urandom);
         a0 = $urandom;
         a1 = $urandom;
         if (f3 == 3'd5 && n < 40) a0 = 32'h0;
         doCmd(f3, f7, a0, a1, d, l, e, el);
         assertCount++;
         if (d !== e || l != el) begin
            failCount++;
            $display("[TB] FAIL random%0d_op%0d: got %h lat %0d expected %h lat %0d",
                     n, f3, d, l, e, el);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_dot();
      test_back_to_back();
      test_reset_mid_run();
      test_bsum();
      test_offset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
